// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and BCD helpers for the countdown timer
package timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSE   = 2'd2,
      ST_EXPIRED = 2'd3
   } timer_state_t;

   localparam int         BCD_W   = 4;
   localparam logic [3:0] BCD_MAX = 4'd9;

   // Clamp an out-of-range nibble to the largest legal BCD digit.
   function automatic logic [BCD_W-1:0] bcd_sanitise(input logic [BCD_W-1:0] nib);
      return (nib > BCD_MAX) ? BCD_MAX : nib;
   endfunction

endpackage

// File: rtl/countdown_timer_bcd_if.sv
// rtl/countdown_timer_bcd_if.sv - control and status bundle of the countdown timer
interface countdown_timer_bcd_if #(
   parameter int NUM_DIGITS = 3
);
   import timer_pkg::*;

   logic                          reconfig;
   logic                          start;
   logic                          pause;
   logic [BCD_W*NUM_DIGITS-1:0]   number;
   logic                          running;
   logic                          warn;
   logic                          expired;
   logic                          timeout;

   modport master (
      output reconfig, start, pause,
      input  number, running, warn, expired, timeout
   );

   modport slave (
      input  reconfig, start, pause,
      output number, running, warn, expired, timeout
   );

endinterface

// File: rtl/bcd_digit_down.sv
// rtl/bcd_digit_down.sv - one BCD digit of a down-counting borrow chain
module bcd_digit_down
   import timer_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [BCD_W-1:0] load_value,
   input  logic             borrow_in,
   output logic [BCD_W-1:0] digit,
   output logic             borrow_out,
   output logic             is_zero
);

   assign is_zero    = (digit == '0);
   assign borrow_out = borrow_in && is_zero;

   // Load wins over a decrement; a borrow into a zero digit wraps it to 9.
   always_ff @(posedge clk) begin
      if (rst) begin
         digit <= '0;
      end else if (load) begin
         digit <= load_value;
      end else if (borrow_in) begin
         digit <= is_zero ? BCD_MAX : digit - 4'd1;
      end
   end

endmodule

// File: rtl/countdown_timer_bcd.sv
// rtl/countdown_timer_bcd.sv - multi-digit BCD countdown timer with prescaler and timeout pulse
module countdown_timer_bcd
   import timer_pkg::*;
#(
   parameter int                          NUM_DIGITS   = 3,
   parameter logic [BCD_W*NUM_DIGITS-1:0] RELOAD_VALUE = 12'h120,
   parameter int                          PRESCALE     = 50_000_000,
   parameter logic [BCD_W*NUM_DIGITS-1:0] WARN_VALUE   = 12'h010
) (
   input  logic                 clk,
   input  logic                 rst,
   countdown_timer_bcd_if.slave bus
);

   localparam int            NW         = BCD_W * NUM_DIGITS;
   localparam int            PW         = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

   timer_state_t          state;
   timer_state_t          next_state;
   logic [PW-1:0]         presc;
   logic [NW-1:0]         number;
   logic [NUM_DIGITS:0]   borrow;
   logic [NUM_DIGITS-1:0] is_zero;
   logic [NUM_DIGITS-1:0] zero_mask;
   logic                  tick;
   logic                  all_zero;
   logic                  last_count;
   logic                  timeout_q;

   // A tick only counts when nothing of higher priority is asserted.
   assign tick       = (state == ST_RUN) && !bus.reconfig && !bus.pause && (presc == PRESC_LAST);
   assign borrow[0]  = tick;
   assign all_zero   = &is_zero;
   // Number is exactly 1: digit 0 is 1 and every digit above it is zero.
   assign zero_mask  = is_zero | NUM_DIGITS'(1);
   assign last_count = (number[BCD_W-1:0] == 4'd1) && (&zero_mask);

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      localparam logic [BCD_W-1:0] LOAD_NIB = bcd_sanitise(RELOAD_VALUE[i*BCD_W +: BCD_W]);

      bcd_digit_down u_digit (
         .clk        (clk),
         .rst        (rst),
         .load       (bus.reconfig),
         .load_value (LOAD_NIB),
         .borrow_in  (borrow[i]),
         .digit      (number[i*BCD_W +: BCD_W]),
         .borrow_out (borrow[i+1]),
         .is_zero    (is_zero[i])
      );
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: reconfig first, then pause over start, then the expiry tick.
   always_comb begin
      next_state = state;
      if (bus.reconfig) begin
         next_state = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:    if (!bus.pause && bus.start && !all_zero) next_state = ST_RUN;
            ST_RUN:     if (bus.pause) next_state = ST_PAUSE;
                        else if (tick && last_count) next_state = ST_EXPIRED;
            ST_PAUSE:   if (bus.start && !bus.pause) next_state = ST_RUN;
            ST_EXPIRED: next_state = ST_EXPIRED;
            default:    next_state = ST_IDLE;
         endcase
      end
   end

   // Prescaler: restarts on a fresh run, holds through pause so partial periods survive.
   always_ff @(posedge clk) begin
      if (rst || bus.reconfig) begin
         presc <= '0;
      end else if (state == ST_IDLE && next_state == ST_RUN) begin
         presc <= '0;
      end else if (state == ST_RUN && !bus.pause) begin
         presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
      end
   end

   // Timeout pulses for the single cycle after the expiring tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= (state == ST_RUN) && (next_state == ST_EXPIRED);
      end
   end

   // Status outputs decoded from the registered state and count.
   always_comb begin
      bus.number  = number;
      bus.running = (state == ST_RUN);
      bus.expired = (state == ST_EXPIRED);
      bus.warn    = (state == ST_RUN) && (number <= WARN_VALUE);
      bus.timeout = timeout_q;
   end

   // Expiry always precedes a borrow out of the top digit.
   always @(posedge clk) begin
      if (!rst) assert (!borrow[NUM_DIGITS]);
   end

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// tb/tb_countdown_timer_bcd.sv - self-checking bench for countdown_timer_bcd
module tb_countdown_timer_bcd;

   typedef enum int {OP_NONE, OP_RECONFIG, OP_START, OP_PAUSE, OP_START_PAUSE} op_t;

   typedef struct {
      logic [11:0] number;
      logic        running;
      logic        warn;
      logic        expired;
      logic        timeout;
      string       name;
   } exp_t;

   typedef struct {
      int          which;
      op_t         op;
      int          cycles;
      logic [11:0] number;
      logic        running;
      logic        warn;
      logic        expired;
      logic        timeout;
      string       name;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   countdown_timer_bcd_if #(.NUM_DIGITS(3)) if_a ();
   countdown_timer_bcd_if #(.NUM_DIGITS(3)) if_b ();
   countdown_timer_bcd_if #(.NUM_DIGITS(3)) if_c ();

   countdown_timer_bcd #(.NUM_DIGITS(3), .RELOAD_VALUE(12'h120), .PRESCALE(4), .WARN_VALUE(12'h010))
      dut_a (.clk(clk), .rst(rst), .bus(if_a));
   countdown_timer_bcd #(.NUM_DIGITS(3), .RELOAD_VALUE(12'h002), .PRESCALE(4), .WARN_VALUE(12'h010))
      dut_b (.clk(clk), .rst(rst), .bus(if_b));
   countdown_timer_bcd #(.NUM_DIGITS(3), .RELOAD_VALUE(12'h1AF), .PRESCALE(4), .WARN_VALUE(12'h010))
      dut_c (.clk(clk), .rst(rst), .bus(if_c));

   exp_t sb[$];
   vec_t tbl[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   function automatic logic [11:0] bcd_dec(input logic [11:0] b);
      int v;
      v = int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]) - 1;
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic vec_t mk(input int which, input op_t op, input int cycles,
                               input logic [11:0] number, input logic running, input logic warn,
                               input logic expired, input logic timeout, input string name);
      vec_t v;
      v.which = which; v.op = op; v.cycles = cycles; v.number = number;
      v.running = running; v.warn = warn; v.expired = expired; v.timeout = timeout;
      v.name = name;
      return v;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input int which, input op_t op);
      logic r, s, p;
      r = (op == OP_RECONFIG);
      s = (op == OP_START) || (op == OP_START_PAUSE);
      p = (op == OP_PAUSE) || (op == OP_START_PAUSE);
      case (which)
         0:       begin if_a.reconfig = r; if_a.start = s; if_a.pause = p; end
         1:       begin if_b.reconfig = r; if_b.start = s; if_b.pause = p; end
         default: begin if_c.reconfig = r; if_c.start = s; if_c.pause = p; end
      endcase
   endtask

   task automatic expect_out(input vec_t v);
      exp_t x;
      x.number = v.number; x.running = v.running; x.warn = v.warn;
      x.expired = v.expired; x.timeout = v.timeout; x.name = v.name;
      sb.push_back(x);
   endtask

   task automatic check_out(input int which);
      exp_t        x;
      logic [15:0] act;
      logic [15:0] req;
      x = sb.pop_front();
      case (which)
         0:       act = {if_a.number, if_a.running, if_a.warn, if_a.expired, if_a.timeout};
         1:       act = {if_b.number, if_b.running, if_b.warn, if_b.expired, if_b.timeout};
         default: act = {if_c.number, if_c.running, if_c.warn, if_c.expired, if_c.timeout};
      endcase
      req = {x.number, x.running, x.warn, x.expired, x.timeout};
      n_checks++;
      if (act === req) begin
         n_pass++;
      end else begin
         $display("FAIL %s (dut %0d): got number=%h run=%b warn=%b exp=%b to=%b, required number=%h run=%b warn=%b exp=%b to=%b",
                  x.name, which, act[15:4], act[3], act[2], act[1], act[0],
                  req[15:4], req[3], req[2], req[1], req[0]);
      end
   endtask

   // Apply one op for a single edge, idle for the rest of the row, then compare.
   task automatic run_row(input vec_t v);
      expect_out(v);
      drive(v.which, v.op);
      step(1);
      drive(v.which, OP_NONE);
      if (v.cycles > 1) step(v.cycles - 1);
      check_out(v.which);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0] n;
      drive(0, OP_NONE);
      drive(1, OP_NONE);
      drive(2, OP_NONE);

      // Main sequence on the 120 reload timer.
      tbl.push_back(mk(0, OP_RECONFIG,    1, 12'h120, 0, 0, 0, 0, "reconfig_load"));
      tbl.push_back(mk(0, OP_NONE,        3, 12'h120, 0, 0, 0, 0, "idle_hold"));
      tbl.push_back(mk(0, OP_START,       1, 12'h120, 1, 0, 0, 0, "start_running"));
      tbl.push_back(mk(0, OP_NONE,        3, 12'h120, 1, 0, 0, 0, "before_first_tick"));
      tbl.push_back(mk(0, OP_NONE,        1, 12'h119, 1, 0, 0, 0, "first_dec"));
      tbl.push_back(mk(0, OP_NONE,        4, 12'h118, 1, 0, 0, 0, "second_dec"));
      tbl.push_back(mk(0, OP_NONE,        2, 12'h118, 1, 0, 0, 0, "pre_pause"));
      tbl.push_back(mk(0, OP_PAUSE,       1, 12'h118, 0, 0, 0, 0, "pause_enter"));
      tbl.push_back(mk(0, OP_NONE,       10, 12'h118, 0, 0, 0, 0, "pause_hold"));
      tbl.push_back(mk(0, OP_START,       1, 12'h118, 1, 0, 0, 0, "resume"));
      tbl.push_back(mk(0, OP_NONE,        1, 12'h118, 1, 0, 0, 0, "resume_partial"));
      tbl.push_back(mk(0, OP_NONE,        1, 12'h117, 1, 0, 0, 0, "resume_dec"));
      tbl.push_back(mk(0, OP_START_PAUSE, 1, 12'h117, 0, 0, 0, 0, "start_pause_in_run"));
      tbl.push_back(mk(0, OP_START_PAUSE, 2, 12'h117, 0, 0, 0, 0, "start_pause_in_pause"));
      tbl.push_back(mk(0, OP_START,       1, 12'h117, 1, 0, 0, 0, "resume2"));
      tbl.push_back(mk(0, OP_NONE,        3, 12'h117, 1, 0, 0, 0, "resume2_hold"));
      tbl.push_back(mk(0, OP_NONE,        1, 12'h116, 1, 0, 0, 0, "resume2_dec"));

      // Outputs while reset is held.
      step(2);
      for (int w = 0; w < 3; w++) begin
         expect_out(mk(w, OP_NONE, 1, 12'h000, 0, 0, 0, 0, "in_reset"));
         check_out(w);
      end
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) run_row(tbl[i]);

      // Count down through 110->109, 100->099 and into the warn window.
      n = 12'h116;
      while (n != 12'h010) begin
         n = bcd_dec(n);
         run_row(mk(0, OP_NONE, 4, n, 1, (n <= 12'h010), 0, 0, $sformatf("tick_%h", n)));
      end
      run_row(mk(0, OP_PAUSE,    1, 12'h010, 0, 0, 0, 0, "warn_drop_on_pause"));
      run_row(mk(0, OP_RECONFIG, 1, 12'h120, 0, 0, 0, 0, "reconfig_from_pause"));

      // Reload sanitising: 1AF loads as 199.
      run_row(mk(2, OP_RECONFIG, 1, 12'h199, 0, 0, 0, 0, "sanitise_load"));

      // Expiry sequence on the 002 reload timer.
      run_row(mk(1, OP_START,    1, 12'h000, 0, 0, 0, 0, "start_at_zero_ignored"));
      run_row(mk(1, OP_RECONFIG, 1, 12'h002, 0, 0, 0, 0, "b_reconfig"));
      run_row(mk(1, OP_START,    1, 12'h002, 1, 1, 0, 0, "b_start"));
      run_row(mk(1, OP_NONE,     4, 12'h001, 1, 1, 0, 0, "b_dec_001"));
      run_row(mk(1, OP_NONE,     3, 12'h001, 1, 1, 0, 0, "b_hold_001"));
      run_row(mk(1, OP_NONE,     1, 12'h000, 0, 0, 1, 1, "b_expire"));
      run_row(mk(1, OP_NONE,     1, 12'h000, 0, 0, 1, 0, "b_timeout_one_cycle"));
      run_row(mk(1, OP_NONE,     5, 12'h000, 0, 0, 1, 0, "b_expired_stays"));
      run_row(mk(1, OP_START,    1, 12'h000, 0, 0, 1, 0, "b_start_ignored"));
      run_row(mk(1, OP_PAUSE,    1, 12'h000, 0, 0, 1, 0, "b_pause_ignored"));
      run_row(mk(1, OP_RECONFIG, 1, 12'h002, 0, 0, 0, 0, "b_reconfig_exit"));

      // Reconfig on the same edge as the expiring tick.
      run_row(mk(1, OP_START,    1, 12'h002, 1, 1, 0, 0, "c_start"));
      run_row(mk(1, OP_NONE,     4, 12'h001, 1, 1, 0, 0, "c_dec_001"));
      run_row(mk(1, OP_NONE,     3, 12'h001, 1, 1, 0, 0, "c_hold_001"));
      run_row(mk(1, OP_RECONFIG, 1, 12'h002, 0, 0, 0, 0, "reconfig_beats_expiry"));
      run_row(mk(1, OP_NONE,     1, 12'h002, 0, 0, 0, 0, "no_late_timeout"));

      // Reset mid-count: everything clears, no timeout pulse.
      run_row(mk(1, OP_START,    1, 12'h002, 1, 1, 0, 0, "d_start"));
      run_row(mk(1, OP_NONE,     4, 12'h001, 1, 1, 0, 0, "d_dec_001"));
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      for (int w = 0; w < 2; w++) begin
         expect_out(mk(w, OP_NONE, 1, 12'h000, 0, 0, 0, 0, "reset_mid_count"));
         check_out(w);
      end
      run_row(mk(1, OP_NONE,     4, 12'h000, 0, 0, 0, 0, "after_reset_idle"));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
